switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Separable input-first round-robin switch allocator for one router.
- Decides, each cycle, which input port drives each crossbar output, and which VC of each input port is served.
- Drives the crossbar's per-output input-select vector.
- Tracks downstream credits per (output port, downstream VC), so only flits with buffer space downstream are granted.

Parameters:
- PORT_NUM, 5, number of router ports (inputs = outputs).
- VC_NUM, 2, virtual channels per port.
- VC_SIZE, 8, downstream buffer depth per VC; credit counter reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_i  in  [PORT_NUM][VC_NUM]  input VC has an ungranted flit at its head.
- out_port_i  in  [PORT_NUM][VC_NUM] x $clog2(PORT_NUM)  output port requested by each input VC.
- down_vc_i  in  [PORT_NUM][VC_NUM] x $clog2(VC_NUM)  downstream VC already assigned by VC allocation.
- credit_i  in  [PORT_NUM][VC_NUM]  one credit returned from downstream (output port, VC).
- vc_grant_o  out  [PORT_NUM][VC_NUM]  one-hot-or-zero per input port: pop this VC's head flit.
- input_vc_sel_o  out  [PORT_NUM] x $clog2(PORT_NUM)  per output, index of the input port routed through the crossbar.
- valid_sel_o  out  [PORT_NUM]  per output, a flit crosses this cycle.
- out_vc_o  out  [PORT_NUM] x $clog2(VC_NUM)  per output, downstream VC tag of the crossing flit.

Behaviour:
- Reset (rst low, async): all outputs 0; round-robin pointers 0; credit counters = VC_SIZE.
- Eligibility (comb): input VC (i,v) is eligible iff req_i[i][v] and credit[out_port_i[i][v]][down_vc_i[i][v]] > 0.
- Stage 1 (comb): per input i, round-robin pick one eligible VC, starting from in_ptr[i].
- Stage 2 (comb): per output o, round-robin pick one input whose stage-1 winner targets o, starting from out_ptr[o].
- Outputs are registered; latency is 1 cycle, request sampled at cycle t, grant visible at cycle t+1.
- At t+1 for a final winner (i,v)->o:
  - vc_grant_o[i][v]=1.
  - input_vc_sel_o[o]=i.
  - valid_sel_o[o]=1.
  - out_vc_o[o]=down_vc.
- Non-granted outputs: valid_sel_o=0; input_vc_sel_o holds its previous value.
- Pointer update at the clock edge ending the decision cycle, only for final winners:
  - in_ptr[i] moves to v+1 mod VC_NUM.
  - out_ptr[o] moves to i+1 mod PORT_NUM.
  - A stage-1 winner that loses stage 2 does not move in_ptr.
- Handshake: req_i in the cycle vc_grant_o is high must already exclude the flit being granted. Each grant consumes exactly one flit.
- Credits (width $clog2(VC_SIZE+1)):
  - Decrement on grant (decision cycle edge); increment on credit_i.
  - Simultaneous grant and credit: counter unchanged.
  - Count 0 blocks eligibility.
  - Increment at VC_SIZE is an error: counter saturates and a simulation assertion fires.
- Guarantees: at most one grant per input and per output per cycle; no starvation under persistent requests (bounded by PORT_NUM*VC_NUM decisions).
- Reset mid-operation: pending decisions are discarded and credits are restored to VC_SIZE; the surrounding router must also be reset.

Optional Feature:
- Macro SA_PACKET_LOCK_EN.
- Enabled:
  - Extra inputs head_i and tail_i, each [PORT_NUM][VC_NUM].
  - Granting a head flit locks output o to (i,v); only (i,v) may win o until its tail flit is granted, then o unlocks in the same edge.
  - Head+tail in one flit: no lock held.
  - Lock state resets to unlocked.
- Disabled: ports absent; every flit is arbitrated independently (flit-level VC interleaving).

Decomposition:
- noc_params package holds:
  - PORT_NUM, VC_NUM, VC_SIZE.
  - port_t enum (LOCAL, NORTH, SOUTH, WEST, EAST).
  - Derived widths PORT_SIZE = $clog2(PORT_NUM) and VC_W = $clog2(VC_NUM).
- Sub-module round_robin_arbiter #(N):
  - Inputs: request vector, update enable.
  - Output: one-hot grant.
  - Internal rotating pointer.
  - Instantiated PORT_NUM times per stage.

Test Plan:
- Reset: rst low, then high -> all outputs 0; single req (0,0)->port 2 gives vc_grant_o[0]=01, input_vc_sel_o[2]=0, valid_sel_o[2]=1 exactly one cycle later.
- Output contention: inputs 1,3,4 request output 0 continuously -> grants to inputs 1,3,4,1,3,4 on consecutive cycles.
- VC fairness: input 2 VC0 and VC1 both target distinct free outputs -> VC0, VC1 granted alternately.
- Credit exhaustion: VC_SIZE=8, no credit_i -> 8 grants to output 1 VC0, then valid_sel_o[1]=0; one credit_i pulse -> exactly one more grant.
- Simultaneous grant and credit_i on the same counter -> value unchanged (check 3 stays 3).
- SA_PACKET_LOCK_EN: input 0 sends head, body, tail to output 4 while input 1 also requests output 4 -> input 1 granted only the cycle after input 0's tail grant.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_params (package)
//  Purpose  : Router-wide sizing constants, port naming and width helper.
//  Revision : 1.0  initial release
// ============================================================================
package noc_params;

    localparam int PORT_NUM = 5;
    localparam int VC_NUM   = 2;
    localparam int VC_SIZE  = 8;

    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    // Index width that never collapses to zero for single-entry arrays.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_allocator_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : round_robin_arbiter
//  Purpose  : N-way round-robin arbiter; pointer advances past the winner
//             only when the caller confirms the grant was used.
//  Revision : 1.0  initial release
// ============================================================================
module round_robin_arbiter
    import noc_params::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             update_en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;
    int               w_idx;
    logic [IDX_W-1:0] w_sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        w_sel     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_sel = IDX_W'(w_idx);
            if (!w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (update_en && w_found) begin
            r_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : switch_allocator
//  Purpose  : Separable input-first round-robin switch allocator with
//             downstream credit tracking. Optional wormhole packet locking
//             is enabled by defining SA_PACKET_LOCK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module switch_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM = noc_params::PORT_NUM,
    parameter int VC_NUM   = noc_params::VC_NUM,
    parameter int VC_SIZE  = noc_params::VC_SIZE,
    localparam int c_PORT_W = idx_w(PORT_NUM),
    localparam int c_VC_W   = idx_w(VC_NUM),
    localparam int c_CRED_W = $clog2(VC_SIZE + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]               req_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][c_PORT_W-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][c_VC_W-1:0]   down_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]               credit_i,
`ifdef SA_PACKET_LOCK_EN
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]               head_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]               tail_i,
`endif
    output logic [PORT_NUM-1:0][VC_NUM-1:0]               vc_grant_o,
    output logic [PORT_NUM-1:0][c_PORT_W-1:0]             input_vc_sel_o,
    output logic [PORT_NUM-1:0]                           valid_sel_o,
    output logic [PORT_NUM-1:0][c_VC_W-1:0]               out_vc_o
);

    logic [PORT_NUM-1:0][VC_NUM-1:0][c_CRED_W-1:0] r_credit;

    logic [PORT_NUM-1:0][VC_NUM-1:0]   w_elig;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   w_lock_ok;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   w_s1_gnt;
    logic [PORT_NUM-1:0][c_VC_W-1:0]   w_s1_vc;
    logic [PORT_NUM-1:0]               w_s1_valid;
    logic [PORT_NUM-1:0][c_PORT_W-1:0] w_s1_port;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] w_s2_req;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] w_s2_gnt;
    logic [PORT_NUM-1:0][c_PORT_W-1:0] w_s2_idx;
    logic [PORT_NUM-1:0]               w_out_valid;
    logic [PORT_NUM-1:0][c_VC_W-1:0]   w_win_vc;
    logic [PORT_NUM-1:0][c_VC_W-1:0]   w_out_vc;
    logic [PORT_NUM-1:0]               w_in_win;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   w_vc_grant;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   w_cred_dec;

    // A VC competes only if its downstream buffer has room and no foreign
    // packet holds the target output.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (req_i[i][v] && (int'(out_port_i[i][v]) < PORT_NUM)
                        && (int'(down_vc_i[i][v]) < VC_NUM)) begin
                    w_elig[i][v] = (r_credit[out_port_i[i][v]][down_vc_i[i][v]] != '0)
                                   && w_lock_ok[i][v];
                end
            end
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in_arb
        round_robin_arbiter #(
            .N     (VC_NUM),
            .IDX_W (c_VC_W)
        ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (w_elig[i]),
            .update_en (w_in_win[i]),
            .grant     (w_s1_gnt[i]),
            .grant_idx (w_s1_vc[i])
        );
    end

    always_comb begin
        w_s1_valid = '0;
        w_s1_port  = '0;
        w_s2_req   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            w_s1_valid[i] = |w_elig[i];
            w_s1_port[i]  = out_port_i[i][w_s1_vc[i]];
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                w_s2_req[o][i] = w_s1_valid[i] && (w_s1_port[i] == c_PORT_W'(o));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
        round_robin_arbiter #(
            .N     (PORT_NUM),
            .IDX_W (c_PORT_W)
        ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (w_s2_req[o]),
            .update_en (w_out_valid[o]),
            .grant     (w_s2_gnt[o]),
            .grant_idx (w_s2_idx[o])
        );
    end

    always_comb begin
        w_in_win    = '0;
        w_vc_grant  = '0;
        w_out_valid = '0;
        w_win_vc    = '0;
        w_out_vc    = '0;
        w_cred_dec  = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            w_out_valid[o] = |w_s2_req[o];
            w_win_vc[o]    = w_s1_vc[w_s2_idx[o]];
            w_out_vc[o]    = down_vc_i[w_s2_idx[o]][w_win_vc[o]];
            w_in_win       = w_in_win | w_s2_gnt[o];
            for (int v = 0; v < VC_NUM; v++) begin
                w_cred_dec[o][v] = w_out_valid[o] && (w_out_vc[o] == c_VC_W'(v));
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            w_vc_grant[i] = w_in_win[i] ? w_s1_gnt[i] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vc_grant_o     <= '0;
            valid_sel_o    <= '0;
            input_vc_sel_o <= '0;
            out_vc_o       <= '0;
        end else begin
            vc_grant_o  <= w_vc_grant;
            valid_sel_o <= w_out_valid;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (w_out_valid[o]) begin
                    input_vc_sel_o[o] <= w_s2_idx[o];
                    out_vc_o[o]       <= w_out_vc[o];
                end
            end
        end
    end

    // Grant and returned credit in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    r_credit[o][v] <= c_CRED_W'(VC_SIZE);
                end
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (w_cred_dec[o][v] && !credit_i[o][v]) begin
                        r_credit[o][v] <= r_credit[o][v] - 1'b1;
                    end else if (!w_cred_dec[o][v] && credit_i[o][v]
                                 && (r_credit[o][v] != c_CRED_W'(VC_SIZE))) begin
                        r_credit[o][v] <= r_credit[o][v] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_cred_chk_o
        for (genvar v = 0; v < VC_NUM; v++) begin : g_cred_chk_v
            a_credit_overflow: assert property (@(posedge clk) disable iff (!rst)
                !(credit_i[o][v] && !w_cred_dec[o][v]
                  && (r_credit[o][v] == c_CRED_W'(VC_SIZE))));
        end
    end

`ifdef SA_PACKET_LOCK_EN
    logic [PORT_NUM-1:0]               r_lock_valid;
    logic [PORT_NUM-1:0][c_PORT_W-1:0] r_lock_in;
    logic [PORT_NUM-1:0][c_VC_W-1:0]   r_lock_vc;

    always_comb begin
        w_lock_ok = '1;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if ((int'(out_port_i[i][v]) < PORT_NUM) && r_lock_valid[out_port_i[i][v]]) begin
                    w_lock_ok[i][v] = (r_lock_in[out_port_i[i][v]] == c_PORT_W'(i))
                                      && (r_lock_vc[out_port_i[i][v]] == c_VC_W'(v));
                end
            end
        end
    end

    // Tail wins over head so a single-flit packet never leaves a lock behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_valid <= '0;
            r_lock_in    <= '0;
            r_lock_vc    <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (w_out_valid[o]) begin
                    if (tail_i[w_s2_idx[o]][w_win_vc[o]]) begin
                        r_lock_valid[o] <= 1'b0;
                    end else if (head_i[w_s2_idx[o]][w_win_vc[o]]) begin
                        r_lock_valid[o] <= 1'b1;
                        r_lock_in[o]    <= w_s2_idx[o];
                        r_lock_vc[o]    <= w_win_vc[o];
                    end
                end
            end
        end
    end
`else
    assign w_lock_ok = '1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_allocator
//  Purpose  : Directed self-checking bench for switch_allocator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_allocator;
    import noc_params::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [4:0][1:0]      req_i;
    logic [4:0][1:0][2:0] out_port_i;
    logic [4:0][1:0][0:0] down_vc_i;
    logic [4:0][1:0]      credit_i;
`ifdef SA_PACKET_LOCK_EN
    logic [4:0][1:0]      head_i;
    logic [4:0][1:0]      tail_i;
`endif
    logic [4:0][1:0]      vc_grant_o;
    logic [4:0][2:0]      input_vc_sel_o;
    logic [4:0]           valid_sel_o;
    logic [4:0][0:0]      out_vc_o;

    int n_checks = 0;
    int n_fail   = 0;

    switch_allocator u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .out_port_i     (out_port_i),
        .down_vc_i      (down_vc_i),
        .credit_i       (credit_i),
`ifdef SA_PACKET_LOCK_EN
        .head_i         (head_i),
        .tail_i         (tail_i),
`endif
        .vc_grant_o     (vc_grant_o),
        .input_vc_sel_o (input_vc_sel_o),
        .valid_sel_o    (valid_sel_o),
        .out_vc_o       (out_vc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_i      = '0;
        out_port_i = '0;
        down_vc_i  = '0;
        credit_i   = '0;
`ifdef SA_PACKET_LOCK_EN
        head_i     = '0;
        tail_i     = '0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_seq[6];
        exp_seq = '{1, 3, 4, 1, 3, 4};

        // Reset values
        do_reset();
        check("rst_vc_grant", 32'(vc_grant_o), 32'h0);
        check("rst_valid", 32'(valid_sel_o), 32'h0);
        check("rst_sel", 32'(input_vc_sel_o), 32'h0);
        check("rst_out_vc", 32'(out_vc_o), 32'h0);

        // Single request, one-cycle latency
        req_i[0][0]      = 1'b1;
        out_port_i[0][0] = SOUTH;
        step();
        req_i = '0;
        check("single_vc_grant", 32'(vc_grant_o), 32'h001);
        check("single_sel2", 32'(input_vc_sel_o[2]), 32'd0);
        check("single_valid", 32'(valid_sel_o), 32'b00100);
        step();
        check("single_idle_valid", 32'(valid_sel_o), 32'h0);
        check("single_idle_grant", 32'(vc_grant_o), 32'h0);

        // Asynchronous reset while a grant is showing
        req_i[3][1]      = 1'b1;
        out_port_i[3][1] = EAST;
        down_vc_i[3][1]  = 1'b1;
        step();
        req_i = '0;
        check("midrst_pre_sel", 32'(input_vc_sel_o[4]), 32'd3);
        check("midrst_pre_vc", 32'(out_vc_o[4]), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(valid_sel_o), 32'h0);
        check("midrst_grant", 32'(vc_grant_o), 32'h0);
        check("midrst_sel", 32'(input_vc_sel_o), 32'h0);

        // Output contention: inputs 1,3,4 all want output 0
        do_reset();
        req_i[1][0] = 1'b1;
        req_i[3][0] = 1'b1;
        req_i[4][0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("cont_valid0", 32'(valid_sel_o[0]), 32'd1);
            check("cont_sel0", 32'(input_vc_sel_o[0]), 32'(exp_seq[k]));
            check("cont_grant", 32'(vc_grant_o), 32'h1 << (2 * exp_seq[k]));
        end

        // VC fairness on input 2
        do_reset();
        req_i[2]         = 2'b11;
        out_port_i[2][0] = NORTH;
        out_port_i[2][1] = WEST;
        down_vc_i[2][1]  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("fair_vc", 32'(vc_grant_o[2]), (k % 2 == 0) ? 32'b01 : 32'b10);
            check("fair_valid", 32'(valid_sel_o), (k % 2 == 0) ? 32'b00010 : 32'b01000);
            if (k % 2 == 1) begin
                check("fair_out_vc3", 32'(out_vc_o[3]), 32'd1);
            end
        end

        // Credit exhaustion and single returned credit
        do_reset();
        req_i[0][0]      = 1'b1;
        out_port_i[0][0] = NORTH;
        for (int k = 0; k < 10; k++) begin
            step();
            check("exh_valid1", 32'(valid_sel_o[1]), (k < 8) ? 32'd1 : 32'd0);
        end
        credit_i[1][0] = 1'b1;
        step();
        credit_i = '0;
        check("exh_credit_edge", 32'(valid_sel_o[1]), 32'd0);
        step();
        check("exh_one_more", 32'(valid_sel_o[1]), 32'd1);
        step();
        check("exh_after1", 32'(valid_sel_o[1]), 32'd0);
        step();
        check("exh_after2", 32'(valid_sel_o[1]), 32'd0);

        // Grant and credit in the same cycle leave the counter at 3
        do_reset();
        req_i[0][0]      = 1'b1;
        out_port_i[0][0] = NORTH;
        for (int k = 0; k < 5; k++) begin
            step();
            check("sim_pre", 32'(valid_sel_o[1]), 32'd1);
        end
        credit_i[1][0] = 1'b1;
        step();
        credit_i = '0;
        check("sim_edge", 32'(valid_sel_o[1]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("sim_post", 32'(valid_sel_o[1]), (k < 3) ? 32'd1 : 32'd0);
        end

        // Input 0 sends a 3-flit packet to EAST while input 1 also wants EAST
        do_reset();
        req_i[0][0]      = 1'b1;
        out_port_i[0][0] = EAST;
        req_i[1][0]      = 1'b1;
        out_port_i[1][0] = EAST;
`ifdef SA_PACKET_LOCK_EN
        head_i[0][0] = 1'b1;
        head_i[1][0] = 1'b1;
        tail_i[1][0] = 1'b1;
        step();
        check("lock_head", 32'(input_vc_sel_o[4]), 32'd0);
        head_i[0][0] = 1'b0;
        step();
        check("lock_body", 32'(input_vc_sel_o[4]), 32'd0);
        check("lock_body_in1", 32'(vc_grant_o[1]), 32'd0);
        tail_i[0][0] = 1'b1;
        step();
        check("lock_tail", 32'(input_vc_sel_o[4]), 32'd0);
        check("lock_tail_in1", 32'(vc_grant_o[1]), 32'd0);
        req_i[0][0]  = 1'b0;
        tail_i[0][0] = 1'b0;
        step();
        check("lock_release_sel", 32'(input_vc_sel_o[4]), 32'd1);
        check("lock_release_valid", 32'(valid_sel_o[4]), 32'd1);
`else
        step();
        check("ilv_first", 32'(input_vc_sel_o[4]), 32'd0);
        step();
        check("ilv_second", 32'(input_vc_sel_o[4]), 32'd1);
        check("ilv_second_grant", 32'(vc_grant_o), 32'h004);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
